// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I core: shadow destination pipeline,
// operand forwarding, load-use stalls, branch flushes and jump sequencing.
module hazard_ctrl #(
    parameter int CNT_W         = 32,
    parameter int JALR_WAIT_MAX = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             br_taken,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             stall_j,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_JWAIT = 2'd1;
    localparam logic [1:0] S_JFIRE = 2'd2;

    localparam int WAIT_W = (JALR_WAIT_MAX < 2) ? 1 : $clog2(JALR_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(JALR_WAIT_MAX - 1);

    logic [6:0] opcode;
    logic [4:0] id_rd, id_rs1, id_rs2;
    logic       use_rs1, use_rs2, writes_rd;
    logic       id_we, id_ld, is_jump, is_jalr;

    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_we, mem_we, wb_we, ex_ld;

    logic [2:0] rs1_res, rs2_res;
    logic       haz_rs1, load_use;

    logic [1:0]        state, next_state;
    logic [WAIT_W-1:0] wait_cnt, wait_next;

    assign opcode = id_instr[6:0];
    assign id_rd  = id_instr[11:7];
    assign id_rs1 = id_instr[19:15];
    assign id_rs2 = id_instr[24:20];

    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_R: begin
                    use_rs1   = 1'b1;
                    use_rs2   = 1'b1;
                    writes_rd = 1'b1;
                end
                OP_I, OP_JALR, OP_LW: begin
                    use_rs1   = 1'b1;
                    writes_rd = 1'b1;
                end
                OP_S, OP_B: begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OP_JAL, OP_LUI: writes_rd = 1'b1;
                default: ;
            endcase
        end
    end

    assign id_we   = writes_rd && (id_rd != 5'd0);
    assign id_ld   = id_we && (opcode == OP_LW);
    assign is_jump = id_valid && ((opcode == OP_JAL) || (opcode == OP_JALR));
    assign is_jalr = id_valid && (opcode == OP_JALR);

    // Returns {load_use_hazard, select}; the youngest matching producer wins.
    function automatic logic [2:0] resolve(
        input logic       used,
        input logic [4:0] rs,
        input logic [4:0] e_rd, input logic e_we, input logic e_ld,
        input logic [4:0] m_rd, input logic m_we,
        input logic [4:0] w_rd, input logic w_we
    );
        resolve = 3'b000;
        if (used && (rs != 5'd0)) begin
            if (e_we && (e_rd == rs))      resolve = e_ld ? 3'b100 : 3'b001;
            else if (m_we && (m_rd == rs)) resolve = 3'b010;
            else if (w_we && (w_rd == rs)) resolve = 3'b011;
        end
    endfunction

    assign rs1_res  = resolve(use_rs1, id_rs1, ex_rd, ex_we, ex_ld, mem_rd, mem_we, wb_rd, wb_we);
    assign rs2_res  = resolve(use_rs2, id_rs2, ex_rd, ex_we, ex_ld, mem_rd, mem_we, wb_rd, wb_we);
    assign haz_rs1  = rs1_res[2];
    assign load_use = rs1_res[2] | rs2_res[2];

    // A taken branch wins over every stall; the jump FSM absorbs any coincident load-use stall.
    always_comb begin
        next_state  = state;
        wait_next   = wait_cnt;
        fwd_rs1_sel = 2'd0;
        fwd_rs2_sel = 2'd0;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        stall_j     = 1'b0;
        if (rst) begin
            next_state = S_IDLE;
            wait_next  = '0;
        end else begin
            fwd_rs1_sel = rs1_res[1:0];
            fwd_rs2_sel = rs2_res[1:0];
            if (br_taken) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
                next_state = S_IDLE;
                wait_next  = '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (is_jump) begin
                            stall_pc   = 1'b1;
                            stall_ifid = 1'b1;
                            flush_idex = 1'b1;
                            next_state = (is_jalr && haz_rs1) ? S_JWAIT : S_JFIRE;
                        end else if (load_use) begin
                            stall_pc   = 1'b1;
                            stall_ifid = 1'b1;
                            flush_idex = 1'b1;
                        end
                    end
                    S_JWAIT: begin
                        stall_pc   = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                        if (!haz_rs1 || (wait_cnt == WAIT_LAST)) begin
                            next_state = S_JFIRE;
                            wait_next  = '0;
                        end else begin
                            wait_next = wait_cnt + 1'b1;
                        end
                    end
                    S_JFIRE: begin
                        stall_j    = 1'b1;
                        flush_ifid = 1'b1;
                        next_state = S_IDLE;
                    end
                    default: next_state = S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
        end
    end

    // A bubble entering EX keeps its rd but can neither write nor be a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rd  <= '0;
            ex_we  <= 1'b0;
            ex_ld  <= 1'b0;
            mem_rd <= '0;
            mem_we <= 1'b0;
            wb_rd  <= '0;
            wb_we  <= 1'b0;
        end else begin
            wb_rd  <= mem_rd;
            wb_we  <= mem_we;
            mem_rd <= ex_rd;
            mem_we <= ex_we;
            ex_rd  <= id_rd;
            ex_we  <= id_we && !flush_idex;
            ex_ld  <= id_ld && !flush_idex;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_pc && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed programs plus random instruction streams,
// all checked cycle by cycle against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int WAITMAX = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_SYS  = 7'b1110011;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      id_instr;
    logic             id_valid;
    logic             br_taken;
    logic [1:0]       fwd_rs1_sel, fwd_rs2_sel;
    logic             stall_pc, stall_ifid, flush_ifid, flush_idex, stall_j;
    logic [CNT_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .JALR_WAIT_MAX(WAITMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_instr   (id_instr),
        .id_valid   (id_valid),
        .br_taken   (br_taken),
        .fwd_rs1_sel(fwd_rs1_sel),
        .fwd_rs2_sel(fwd_rs2_sel),
        .stall_pc   (stall_pc),
        .stall_ifid (stall_ifid),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .stall_j    (stall_j),
        .stall_cnt  (stall_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    // Model: history of what entered EX, indexed by distance (0=EX, 1=MEM, 2=WB).
    int m_rd[3];
    bit m_we[3];
    bit m_ld[3];
    bit m_fire, m_waiting;
    int m_wait_n, m_cnt;

    int e_sel1, e_sel2;
    bit e_spc, e_sif, e_fif, e_fid, e_sj, e_haz1, e_haz2;
    bit hold_id, squash_id;

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = op;
        w[11:7]  = 5'(rd);
        w[19:15] = 5'(rs1);
        w[24:20] = 5'(rs2);
        return w;
    endfunction

    function automatic bit reads1(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_JALR, OP_LW, OP_S, OP_B};
    endfunction
    function automatic bit reads2(input logic [6:0] op);
        return op inside {OP_R, OP_S, OP_B};
    endfunction
    function automatic bit writes(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_JALR, OP_LW, OP_JAL, OP_LUI};
    endfunction

    task automatic model_fwd(input bit used, input int rs, output int sel, output bit haz);
        sel = 0;
        haz = 0;
        if (used && rs != 0) begin
            for (int d = 0; d < 3; d++) begin
                if (m_we[d] && m_rd[d] == rs) begin
                    if (d == 0 && m_ld[0]) haz = 1;
                    else sel = d + 1;
                    break;
                end
            end
        end
    endtask

    task automatic model_comb();
        logic [6:0] op;
        bit jump;
        op = id_instr[6:0];
        model_fwd(id_valid && reads1(op), int'(id_instr[19:15]), e_sel1, e_haz1);
        model_fwd(id_valid && reads2(op), int'(id_instr[24:20]), e_sel2, e_haz2);
        jump = id_valid && (op == OP_JAL || op == OP_JALR);
        {e_spc, e_sif, e_fif, e_fid, e_sj} = '0;
        if (rst) begin
            e_sel1 = 0;
            e_sel2 = 0;
        end else if (br_taken) begin
            e_fif = 1;
            e_fid = 1;
        end else if (m_fire) begin
            e_sj  = 1;
            e_fif = 1;
        end else if (m_waiting || jump || e_haz1 || e_haz2) begin
            e_spc = 1;
            e_sif = 1;
            e_fid = 1;
        end
    endtask

    task automatic model_seq();
        logic [6:0] op;
        bit jump, we;
        op   = id_instr[6:0];
        jump = id_valid && (op == OP_JAL || op == OP_JALR);
        we   = id_valid && writes(op) && id_instr[11:7] != 5'd0;
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                m_rd[d] = 0;
                m_we[d] = 0;
                m_ld[d] = 0;
            end
            m_fire    = 0;
            m_waiting = 0;
            m_wait_n  = 0;
            m_cnt     = 0;
        end else begin
            if (e_spc && m_cnt < CNT_MAX) m_cnt++;
            if (br_taken) begin
                m_fire    = 0;
                m_waiting = 0;
                m_wait_n  = 0;
            end else if (m_fire) begin
                m_fire = 0;
            end else if (m_waiting) begin
                m_wait_n++;
                if (!e_haz1 || m_wait_n >= WAITMAX) begin
                    m_waiting = 0;
                    m_fire    = 1;
                    m_wait_n  = 0;
                end
            end else if (jump) begin
                if (op == OP_JALR && e_haz1) m_waiting = 1;
                else m_fire = 1;
            end
            for (int d = 2; d > 0; d--) begin
                m_rd[d] = m_rd[d-1];
                m_we[d] = m_we[d-1];
                m_ld[d] = m_ld[d-1];
            end
            m_rd[0] = int'(id_instr[11:7]);
            m_we[0] = we && !e_fid;
            m_ld[0] = we && !e_fid && op == OP_LW;
        end
    endtask

    // One clock: the IF/ID register holds on stall and empties after a flush,
    // so the offered instruction is only consumed when neither applies.
    task automatic applyStimulus(input logic [31:0] instr, input bit valid, input bit br,
                                 input bit r, output bit consumed);
        consumed = 0;
        if (hold_id) begin
        end else if (squash_id) begin
            id_instr = $urandom;
            id_valid = 1'b0;
        end else begin
            id_instr = instr;
            id_valid = valid;
            consumed = 1;
        end
        br_taken = br;
        rst      = r;
        @(negedge clk);
        model_comb();
        checkOutput("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(e_sel1));
        checkOutput("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(e_sel2));
        checkOutput("stall_pc",    32'(stall_pc),    32'(e_spc));
        checkOutput("stall_ifid",  32'(stall_ifid),  32'(e_sif));
        checkOutput("flush_ifid",  32'(flush_ifid),  32'(e_fif));
        checkOutput("flush_idex",  32'(flush_idex),  32'(e_fid));
        checkOutput("stall_j",     32'(stall_j),     32'(e_sj));
        checkOutput("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
        @(posedge clk);
        model_seq();
        hold_id   = e_sif;
        squash_id = e_fif;
        #1;
    endtask

    logic [31:0] prog_q[$];

    task automatic run_prog();
        bit c;
        int guard;
        guard = 0;
        while (prog_q.size() > 0 && guard < 100) begin
            applyStimulus(prog_q[0], 1'b1, 1'b0, 1'b0, c);
            if (c) void'(prog_q.pop_front());
            guard++;
        end
        if (prog_q.size() != 0) begin
            checkOutput("prog_timeout", 32'(prog_q.size()), 32'd0);
            prog_q.delete();
        end
    endtask

    task automatic do_reset();
        bit c;
        applyStimulus(32'h0, 1'b0, 1'b0, 1'b1, c);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops[10];
        ops = '{OP_R, OP_I, OP_JALR, OP_LW, OP_S, OP_B, OP_JAL, OP_LUI, OP_LW, OP_SYS};
        return mk(ops[$urandom_range(0, 9)], $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3));
    endfunction

    initial begin
        logic [31:0] nop;
        bit c;
        nop       = mk(OP_I, 0, 0, 0);
        rst       = 1'b1;
        id_instr  = 32'h0;
        id_valid  = 1'b0;
        br_taken  = 1'b0;
        hold_id   = 0;
        squash_id = 0;
        for (int d = 0; d < 3; d++) begin
            m_rd[d] = 0;
            m_we[d] = 0;
            m_ld[d] = 0;
        end
        m_fire = 0; m_waiting = 0; m_wait_n = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // forwarding distance 1, 2 and 3
        prog_q = '{mk(OP_R, 1, 2, 3), mk(OP_R, 4, 1, 5), mk(OP_R, 1, 2, 3), nop,
                   mk(OP_R, 4, 1, 5), mk(OP_R, 1, 2, 3), nop, nop, mk(OP_R, 4, 1, 5), nop};
        run_prog();
        do_reset();

        // load-use stall then MEM forwarding
        prog_q = '{mk(OP_LW, 6, 0, 0), mk(OP_R, 7, 6, 6), nop, nop};
        run_prog();
        do_reset();

        // jal sequencing
        prog_q = '{mk(OP_JAL, 1, 0, 0), nop, nop, nop};
        run_prog();
        do_reset();

        // jalr waiting on a load
        prog_q = '{mk(OP_LW, 5, 0, 0), mk(OP_JALR, 0, 5, 0), nop, nop, nop};
        run_prog();
        do_reset();

        // taken branch while in JWAIT
        applyStimulus(mk(OP_LW, 5, 0, 0), 1'b1, 1'b0, 1'b0, c);
        applyStimulus(mk(OP_JALR, 0, 5, 0), 1'b1, 1'b0, 1'b0, c);
        applyStimulus(mk(OP_JALR, 0, 5, 0), 1'b1, 1'b1, 1'b0, c);
        repeat (3) applyStimulus(nop, 1'b1, 1'b0, 1'b0, c);
        do_reset();

        // x0 is never a forwarding source
        prog_q = '{mk(OP_R, 0, 1, 2), mk(OP_R, 3, 0, 0), mk(OP_LW, 0, 1, 0), mk(OP_R, 3, 0, 0), nop};
        run_prog();
        do_reset();

        // reset during JFIRE
        applyStimulus(mk(OP_JAL, 1, 0, 0), 1'b1, 1'b0, 1'b0, c);
        applyStimulus(nop, 1'b1, 1'b0, 1'b1, c);
        repeat (2) applyStimulus(nop, 1'b1, 1'b0, 1'b0, c);

        // random streams; the early reset-free stretch drives stall_cnt into saturation
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(rand_instr(), $urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0,
                          (i > 300) && ($urandom_range(0, 99) == 0), c);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
